// File: rtl/packet_injector.sv
// packet_injector: buffers one PE packet, forwards it to the router local port and
// retransmits it on nack. Optional ack timeout is enabled by defining INJ_ACK_TIMEOUT_EN.
module packet_injector #(
  parameter int MY_ID     = 0,
  parameter int MAX_FLITS = 5,
  parameter int MAX_RETRY = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pe_data_in,
  input  logic        pe_write_in,
  output logic        pe_ready_out,
  input  logic [2:0]  capacity_in,
  output logic [31:0] data_out,
  output logic        write_out_signal,
  input  logic        ack_valid_in,
  input  logic        ack_in,
  output logic        done_out,
  output logic        error_out
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {COLLECT, CHECK, SEND, WAIT} state_e;

  state_e        state_q;
  logic [31:0]   flit_q [MAX_FLITS];
  logic [2:0]    flit_cnt_q;
  logic [2:0]    size_q;
  logic [2:0]    send_idx_q;
  logic [RW-1:0] retry_q;
  logic [31:0]   data_q;
  logic          write_q;
  logic          done_q;
  logic          error_q;

  logic [2:0]    hdr_size;
  logic          hdr_ok;
  logic          timeout;
  logic          nack_event;

  // Destination is not interpreted here: packets for the local node go out unchanged.
  logic [4:0]    id_unused;
  assign id_unused = 5'(MY_ID);

  assign hdr_size = pe_data_in[24:22];
  assign hdr_ok   = (hdr_size != 3'd0) && (int'(hdr_size) <= MAX_FLITS);

`ifdef INJ_ACK_TIMEOUT_EN
  logic [7:0] timer_q;

  assign timeout = !ack_valid_in && (timer_q == 8'd255);

  // Held at zero outside WAIT so it always starts from zero on WAIT entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q != WAIT) begin
      timer_q <= '0;
    end else if (!ack_valid_in && (timer_q != 8'd255)) begin
      timer_q <= timer_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign nack_event = (ack_valid_in && !ack_in) || timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= COLLECT;
      flit_cnt_q <= '0;
      size_q     <= '0;
      send_idx_q <= '0;
      retry_q    <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (pe_write_in) begin
            if (flit_cnt_q == 3'd0) begin
              if (!hdr_ok) begin
                error_q <= 1'b1;
              end else begin
                flit_q[0]  <= pe_data_in;
                size_q     <= hdr_size;
                flit_cnt_q <= 3'd1;
                if (hdr_size == 3'd1) state_q <= CHECK;
              end
            end else begin
              flit_q[flit_cnt_q] <= pe_data_in;
              flit_cnt_q         <= flit_cnt_q + 3'd1;
              if ((flit_cnt_q + 3'd1) == size_q) state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (capacity_in >= size_q) begin
            data_q     <= flit_q[0];
            write_q    <= 1'b1;
            send_idx_q <= 3'd1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // Capacity was committed in CHECK; the burst runs to completion.
          if (send_idx_q == size_q) begin
            write_q <= 1'b0;
            state_q <= WAIT;
          end else begin
            data_q     <= flit_q[send_idx_q];
            send_idx_q <= send_idx_q + 3'd1;
          end
        end
        WAIT: begin
          if (ack_valid_in && ack_in) begin
            done_q     <= 1'b1;
            retry_q    <= '0;
            flit_cnt_q <= '0;
            state_q    <= COLLECT;
          end else if (nack_event) begin
            if (int'(retry_q) < MAX_RETRY) begin
              retry_q <= retry_q + RW'(1);
              state_q <= CHECK;
            end else begin
              error_q    <= 1'b1;
              retry_q    <= '0;
              flit_cnt_q <= '0;
              state_q    <= COLLECT;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign pe_ready_out     = (state_q == COLLECT);
  assign data_out         = data_q;
  assign write_out_signal = write_q;
  assign done_out         = done_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: table of packet vectors plus a flit scoreboard.
module tb_packet_injector;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pe_data_in;
  logic        pe_write_in;
  logic        pe_ready_out;
  logic [2:0]  capacity_in;
  logic [31:0] data_out;
  logic        write_out_signal;
  logic        ack_valid_in;
  logic        ack_in;
  logic        done_out;
  logic        error_out;

  always #5 clock = ~clock;

  packet_injector #(.MY_ID(0), .MAX_FLITS(5), .MAX_RETRY(7)) dut (
    .clock            (clock),
    .reset            (reset),
    .pe_data_in       (pe_data_in),
    .pe_write_in      (pe_write_in),
    .pe_ready_out     (pe_ready_out),
    .capacity_in      (capacity_in),
    .data_out         (data_out),
    .write_out_signal (write_out_signal),
    .ack_valid_in     (ack_valid_in),
    .ack_in           (ack_in),
    .done_out         (done_out),
    .error_out        (error_out)
  );

  typedef struct {
    int size_f;    // header size field
    int nflits;    // flits driven by the PE
    int dest;
    int cap_lo;    // capacity held while waiting in CHECK
    int lo_cyc;    // cycles of low capacity
    int cap;       // sufficient capacity
    int ack_delay; // WAIT cycles before each response
    int nacks;
    int exp_tx;    // expected transmissions
    int exp_done;
    int exp_err;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] sb[$];
  logic [31:0] pk[8];
  int          n_checks = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("done_error_exclusive", 32'(done_out & error_out), 32'd0);
      if (write_out_signal) begin
        if (sb.size() == 0) chk("unexpected_write", 32'(write_out_signal), 32'd0);
        else chk("flit_data", data_out, sb.pop_front());
      end
      if (done_out) done_cnt++;
      if (error_out) err_cnt++;
    end
  end

  task automatic send_packet(input vec_t v);
    pk[0] = {2'b00, 5'(v.dest), 3'(v.size_f), 22'($urandom)};
    for (int i = 1; i < 8; i++) pk[i] = $urandom;
    for (int t = 0; t < v.exp_tx; t++)
      for (int i = 0; i < v.size_f; i++) sb.push_back(pk[i]);
    for (int i = 0; i < v.nflits; i++) begin
      chk("pe_ready_collect", 32'(pe_ready_out), 32'd1);
      pe_write_in = 1'b1;
      pe_data_in  = pk[i];
      @(negedge clock);
    end
    pe_write_in = 1'b0;
    pe_data_in  = '0;
  endtask

  task automatic measure_tx(input int size, input int max_wait);
    int w;
    int n;
    w = 0;
    n = 0;
    while (!write_out_signal && w < max_wait) begin
      @(negedge clock);
      w++;
    end
    chk("tx_started", 32'(write_out_signal), 32'd1);
    while (write_out_signal && n < 16) begin
      if (n == 0) capacity_in = 3'd0;
      n++;
      @(negedge clock);
    end
    chk("burst_len", 32'(n), 32'(size));
    chk("data_hold_wait", data_out, pk[size-1]);
  endtask

  task automatic respond(input bit is_ack, input int delay, input int cap);
    chk("ready_low_wait", 32'(pe_ready_out), 32'd0);
    repeat (delay) @(negedge clock);
    ack_valid_in = 1'b1;
    ack_in       = is_ack;
    capacity_in  = 3'(cap);
    @(negedge clock);
    ack_valid_in = 1'b0;
    ack_in       = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    capacity_in = 3'((v.lo_cyc > 0) ? v.cap_lo : v.cap);
    send_packet(v);
    if (v.exp_tx == 0) begin
      chk("hdr_reject_error", 32'(error_out), 32'(v.exp_err));
      chk("hdr_reject_ready", 32'(pe_ready_out), 32'd1);
    end else begin
      for (int i = 0; i < v.lo_cyc; i++) begin
        chk("ready_low_check", 32'(pe_ready_out), 32'd0);
        pe_write_in  = 1'b1;
        pe_data_in   = $urandom;
        ack_valid_in = 1'b1;
        ack_in       = 1'b1;
        @(negedge clock);
        chk("no_write_low_cap", 32'(write_out_signal), 32'd0);
      end
      pe_write_in  = 1'b0;
      pe_data_in   = '0;
      ack_valid_in = 1'b0;
      ack_in       = 1'b0;
      capacity_in  = 3'(v.cap);
      @(negedge clock);
      chk("first_flit_latency", 32'(write_out_signal), 32'd1);
      measure_tx(v.size_f, 0);
      for (int r = 0; r < v.nacks; r++) begin
        respond(1'b0, v.ack_delay, v.cap);
        if (r < v.exp_tx - 1) measure_tx(v.size_f, 4);
      end
      if (v.exp_done != 0) respond(1'b1, v.ack_delay, v.cap);
      chk("done_pulse", 32'(done_out), 32'(v.exp_done));
      chk("error_pulse", 32'(error_out), 32'(v.exp_err));
    end
    @(negedge clock);
    chk("pulse_one_cycle", 32'(done_out | error_out), 32'd0);
    chk("ready_after_pkt", 32'(pe_ready_out), 32'd1);
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
    chk("error_count", 32'(err_cnt - e0), 32'(v.exp_err));
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r5;
    int   w;
    int   d0;
    int   e0;

    reset        = 1'b1;
    pe_data_in   = '0;
    pe_write_in  = 1'b0;
    capacity_in  = 3'd0;
    ack_valid_in = 1'b0;
    ack_in       = 1'b0;

    //          size nfl dest lo lcy cap dly nak tx dn er
    vecs[0] = '{3,   3,  2,   0, 0,  5,  2,  0,  1, 1, 0};
    vecs[1] = '{1,   1,  0,   0, 0,  1,  0,  0,  1, 1, 0};
    vecs[2] = '{5,   5,  31,  0, 0,  7,  1,  2,  3, 1, 0};
    vecs[3] = '{4,   4,  9,   2, 10, 4,  0,  0,  1, 1, 0};
    vecs[4] = '{2,   2,  4,   0, 0,  2,  0,  8,  8, 0, 1};
    vecs[5] = '{0,   1,  3,   0, 0,  5,  0,  0,  0, 0, 1};
    vecs[6] = '{7,   1,  5,   0, 0,  5,  0,  0,  0, 0, 1};
    vecs[7] = '{5,   5,  1,   0, 0,  5,  3,  7,  8, 1, 0};

    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(pe_ready_out), 32'd1);
    chk("rst_write", 32'(write_out_signal), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Reset while the second flit of a 5-flit burst is on the port.
    d0 = done_cnt;
    e0 = err_cnt;
    r5 = '{5, 5, 6, 0, 0, 5, 0, 0, 1, 0, 0};
    capacity_in = 3'd5;
    send_packet(r5);
    w = 0;
    while (!write_out_signal && w < 8) begin
      @(negedge clock);
      w++;
    end
    chk("rstsend_tx_started", 32'(write_out_signal), 32'd1);
    @(negedge clock);
    chk("rstsend_second_flit", 32'(write_out_signal), 32'd1);
    reset        = 1'b1;
    pe_write_in  = 1'b1;
    pe_data_in   = {2'b00, 5'd1, 3'd1, 22'd0};
    ack_valid_in = 1'b1;
    ack_in       = 1'b1;
    @(negedge clock);
    chk("rstsend_write", 32'(write_out_signal), 32'd0);
    chk("rstsend_data", data_out, 32'd0);
    chk("rstsend_ready", 32'(pe_ready_out), 32'd1);
    chk("rstsend_done", 32'(done_out), 32'd0);
    chk("rstsend_error", 32'(error_out), 32'd0);
    sb.delete();
    @(negedge clock);
    reset        = 1'b0;
    pe_write_in  = 1'b0;
    pe_data_in   = '0;
    ack_valid_in = 1'b0;
    ack_in       = 1'b0;
    repeat (4) @(negedge clock);
    chk("rstsend_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstsend_no_error", 32'(err_cnt - e0), 32'd0);

    run_vector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  MY_ID, 0, node id of the attached router;
  MAX_FLITS, 5, packet storage depth in flits;
  MAX_RETRY, 7, number of nack retransmissions before the packet is dropped.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clock, in, 1, single clock, rising edge;
  reset, in, 1, synchronous, active-high;
  pe_data_in, in, 32, flit from the processing element;
  pe_write_in, in, 1, pe_data_in valid this cycle;
  pe_ready_out, out, 1, injector accepts a flit this cycle;
  capacity_in, in, 3, free slots in the router local-port buffer;
  data_out, out, 32, flit to the router local port;
  write_out_signal, out, 1, data_out valid;
  ack_valid_in, in, 1, router response strobe;
  ack_in, in, 1, 1 = ack, 0 = nack (sampled only with ack_valid_in);
  done_out, out, 1, one-cycle pulse on packet acknowledged;
  error_out, out, 1, one-cycle pulse on packet dropped.

Function
REQ-003 The header is the first flit: dest = bits [29:25], size = bits [24:22]; legal size is 1..MAX_FLITS.
REQ-004 The FSM SHALL have the states COLLECT, CHECK, SEND, WAIT.
REQ-005 COLLECT: pe_ready_out = 1. Each cycle with pe_write_in = 1 stores pe_data_in at index flit_cnt, and flit_cnt increments.
REQ-006 COLLECT: if the header size is 0 or greater than MAX_FLITS, the header is discarded, error_out pulses on the next cycle, and the state stays COLLECT.
REQ-007 COLLECT -> CHECK on the edge at which flit number size is stored (a size-1 packet moves to CHECK on the header edge).
REQ-008 pe_ready_out SHALL be 0 in CHECK, SEND and WAIT; pe_write_in in those states is ignored and its data lost.
REQ-009 CHECK: stays while capacity_in < size; moves to SEND when capacity_in >= size.
REQ-010 SEND: write_out_signal = 1 and data_out = flit[i] for exactly size consecutive cycles, i = 0..size-1, with no gaps; capacity_in is not re-sampled during SEND.
REQ-011 The first flit SHALL appear on the cycle immediately after the CHECK cycle that saw sufficient capacity.
REQ-012 After the last flit the state is WAIT; write_out_signal = 0 and data_out holds its last value.
REQ-013 WAIT, ack_valid_in = 1 and ack_in = 1: done_out pulses next cycle, retry_cnt clears, flit_cnt clears, state -> COLLECT.
REQ-014 WAIT, ack_valid_in = 1 and ack_in = 0, retry_cnt < MAX_RETRY: retry_cnt increments, state -> CHECK, and the same stored flits are resent.
REQ-015 WAIT, nack with retry_cnt = MAX_RETRY: error_out pulses next cycle, counters clear, state -> COLLECT.
REQ-016 ack_valid_in outside WAIT SHALL be ignored; an ack_valid_in on the cycle WAIT is entered is honoured.
REQ-017 dest = MY_ID is legal and transmitted unchanged.
REQ-018 done_out and error_out SHALL never be high in the same cycle.

Reset
REQ-019 When reset is sampled high: state = COLLECT, flit_cnt = 0, retry_cnt = 0, write_out_signal = 0, data_out = 0, done_out = 0, error_out = 0, pe_ready_out = 1.
REQ-020 Reset SHALL override all other inputs in the same cycle.
REQ-021 Reset during SEND or WAIT SHALL abandon the packet with no done or error pulse; write_out_signal is 0 on the cycle after reset is sampled.

Configuration
REQ-022 Macro INJ_ACK_TIMEOUT_EN.
  Defined: a timer clears on WAIT entry and increments each WAIT cycle without ack_valid_in; reaching 255 is treated exactly as a nack (REQ-014/015).
  Undefined: WAIT waits for ack_valid_in indefinitely and the timer logic is absent.

Verification
REQ-023 Scenario 1: 3-flit packet (header size = 3, dest = 2), capacity_in = 5, ack after 2 cycles.
  Response: 3 contiguous writes in order, then done_out = 1 for one cycle, pe_ready_out = 1 again.
REQ-024 Scenario 2: 4-flit packet, capacity_in = 2 for 10 cycles, then 4.
  Response: no write_out_signal while capacity is 2; first flit on the cycle after capacity_in becomes 4.
REQ-025 Scenario 3: 2-flit packet nacked 7 times, then nacked an 8th time.
  Response: 8 identical transmissions, then error_out pulse, no done_out.
REQ-026 Scenario 4: header with size = 0, then a header with size = 7.
  Response: error_out pulses twice, no writes, state remains COLLECT.
REQ-027 Scenario 5: reset asserted on the 2nd flit of a 5-flit SEND.
  Response: write_out_signal = 0 next cycle, all outputs at reset values, no done_out or error_out.
REQ-028 Scenario 6 (INJ_ACK_TIMEOUT_EN defined): 1-flit packet, no ack.
  Response: retransmission 256 cycles after WAIT entry, retry_cnt = 1.
